// File: rtl/roce_sq_scheduler_pkg.sv
// Shared types and constants for the send-queue doorbell scheduler.
package roce_sq_scheduler_pkg;

  localparam int PADDR_BITS     = 64;
  localparam int AXIL_DATA_BITS = 32;
  localparam int BUFLEN_BITS    = 48;
  localparam int ACC_BITS       = 4;

  // Default ring geometry.
  localparam int DEF_SQ_DEPTH   = 64;
  localparam int DEF_WQE_BYTES  = 64;

  // WQE fetch request: {accesdesc, buflen, paddr} = 4 + 48 + 64 = 116 bits.
  typedef struct packed {
    logic [ACC_BITS-1:0]    accesdesc;
    logic [BUFLEN_BITS-1:0] buflen;
    logic [PADDR_BITS-1:0]  paddr;
  } dma_req_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sq_sched_state_t;

  // ceil(log2(v)), never less than 1 so a width derived from it is always legal.
  function automatic int clog2s(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/roce_sq_scheduler_rr_arb.sv
// Combinational N-way round-robin pick: the first requester after last_grant wins.
module roce_rr_arb
  #(
    parameter int N   = 8,
    parameter int QPB = 3
  )
  (
    input  logic [N-1:0]   req,
    input  logic [QPB-1:0] last_grant,
    output logic [QPB-1:0] grant,
    output logic           any
  );

  logic [QPB-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest requester after last_grant overwrites the rest.
  // N is a power of two, so the QPB-bit add wraps modulo N and offset N lands back on last_grant.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    for (int off = N; off >= 1; off--) begin
      idx = last_grant + QPB'(off);
      if (req[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/roce_sq_scheduler.sv
// Per-QP send-queue doorbell scheduler: tracks SQ base/prod/cons per QP and issues
// one WQE fetch per grant, round-robin across QPs with outstanding work.
module roce_sq_scheduler
  import roce_sq_scheduler_pkg::*;
  #(
    parameter int          N_QP      = 8,
    parameter int          SQ_DEPTH  = DEF_SQ_DEPTH,
    parameter int          WQE_BYTES = DEF_WQE_BYTES,
    parameter logic [3:0]  ACC_DESC  = 4'h0
  )
  (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [clog2s(N_QP)-1:0]   cfg_qp,
    input  logic                      cfg_en,
    input  logic [PADDR_BITS-1:0]     cfg_base,
    input  logic                      db_valid,
    output logic                      db_ready,
    input  logic [clog2s(N_QP)-1:0]   db_qp,
    input  logic [AXIL_DATA_BITS-1:0] db_prod,
    output logic                      dma_req_valid,
    input  logic                      dma_req_ready,
    output dma_req_t                  dma_req,
    output logic [clog2s(N_QP)-1:0]   dma_req_qp,
    output logic [N_QP-1:0]           sts_pending,
    output logic                      sts_busy
  );

  localparam int QPB       = clog2s(N_QP);
  localparam int IDXB      = clog2s(SQ_DEPTH);
  localparam int WQE_SHIFT = clog2s(WQE_BYTES);

  // Per-QP state
  logic                  en_reg   [N_QP];
  logic [PADDR_BITS-1:0] base_reg [N_QP];
  logic [IDXB-1:0]       prod_reg [N_QP];
  logic [IDXB-1:0]       cons_reg [N_QP];
  logic [N_QP-1:0]       pending;

  // Scheduler state
  sq_sched_state_t state_reg, state_next;
  logic [QPB-1:0]  cur_qp_reg, cur_qp_next;
  logic [QPB-1:0]  last_grant_reg, last_grant_next;
  dma_req_t        req_reg, req_next;

  logic            cfg_fire;
  logic            req_fire;
  logic [QPB-1:0]  arb_grant;
  logic            arb_any;

  // Only the index bits of the doorbell value carry meaning.
  logic unused_db_bits;
  assign unused_db_bits = ^db_prod[AXIL_DATA_BITS-1:IDXB];

  // A QP with a fetch in flight cannot be reconfigured until its request is accepted.
  assign cfg_ready = !((state_reg == ISSUE) && (cfg_qp == cur_qp_reg));
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign req_fire  = (state_reg == ISSUE) && dma_req_ready;
  assign db_ready  = 1'b1;

  generate
    for (genvar gi = 0; gi < N_QP; gi++) begin : g_qp
      logic cfg_hit;
      logic db_hit;
      logic cons_hit;

      assign cfg_hit  = cfg_fire && (cfg_qp == QPB'(gi));
      assign db_hit   = db_valid && (db_qp == QPB'(gi)) && en_reg[gi];
      assign cons_hit = req_fire && (cur_qp_reg == QPB'(gi));
      assign pending[gi] = en_reg[gi] && (prod_reg[gi] != cons_reg[gi]);

      // Config clears the ring and takes priority over a same-cycle doorbell.
      always_ff @(posedge aclk) begin
        if (areset) begin
          en_reg[gi]   <= 1'b0;
          base_reg[gi] <= '0;
          prod_reg[gi] <= '0;
          cons_reg[gi] <= '0;
        end else if (cfg_hit) begin
          en_reg[gi]   <= cfg_en;
          base_reg[gi] <= cfg_base;
          prod_reg[gi] <= '0;
          cons_reg[gi] <= '0;
        end else begin
          if (db_hit)   prod_reg[gi] <= db_prod[IDXB-1:0];
          if (cons_hit) cons_reg[gi] <= cons_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  roce_rr_arb #(
    .N   (N_QP),
    .QPB (QPB)
  ) u_arb (
    .req        (pending),
    .last_grant (last_grant_reg),
    .grant      (arb_grant),
    .any        (arb_any)
  );

  // Next-state logic: latch the winning QP's fetch in IDLE, hold it stable through ISSUE.
  always_comb begin
    state_next      = state_reg;
    cur_qp_next     = cur_qp_reg;
    last_grant_next = last_grant_reg;
    req_next        = req_reg;
    case (state_reg)
      IDLE: begin
        if (arb_any) begin
          state_next         = ISSUE;
          cur_qp_next        = arb_grant;
          req_next.accesdesc = ACC_DESC;
          req_next.buflen    = BUFLEN_BITS'(WQE_BYTES);
          req_next.paddr     = base_reg[arb_grant]
                             + (PADDR_BITS'(cons_reg[arb_grant]) << WQE_SHIFT);
        end
      end
      ISSUE: begin
        if (dma_req_ready) begin
          state_next      = IDLE;
          last_grant_next = cur_qp_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Scheduler registers; reset drops any in-flight request.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg      <= IDLE;
      cur_qp_reg     <= '0;
      last_grant_reg <= QPB'(N_QP - 1);
      req_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      cur_qp_reg     <= cur_qp_next;
      last_grant_reg <= last_grant_next;
      req_reg        <= req_next;
    end
  end

  assign dma_req_valid = (state_reg == ISSUE);
  assign dma_req       = req_reg;
  assign dma_req_qp    = cur_qp_reg;
  assign sts_pending   = pending;
  assign sts_busy      = (state_reg == ISSUE);

endmodule
